// File: rtl/dev_bus_master_pkg.sv
// dev_bus_master_pkg: shared device-port width and initiator state encodings
package dev_bus_master_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int CNT_WIDTH  = 4;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/dev_latency_timer.sv
// dev_latency_timer: loadable down-counter flagging the final wait cycle
module dev_latency_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last
);
    logic [W-1:0] cnt;
    // load wins over decrement; stops at zero so an idle timer never wraps
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec && cnt != '0) cnt <= cnt - 1'b1;
    assign last = cnt == W'(1);
endmodule

// File: rtl/dev_bus_master.sv
// dev_bus_master: single-outstanding initiator for the OR-combined device port
module dev_bus_master #(
    parameter int DATA_WIDTH   = dev_bus_master_pkg::DATA_WIDTH,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  dev_en,
    output logic                  dev_we,
    output logic [DATA_WIDTH-1:0] dev_address,
    output logic [DATA_WIDTH-1:0] dev_wdata,
    input  logic [DATA_WIDTH-1:0] dev_rdata
);
    import dev_bus_master_pkg::*;
    state_t                state, state_n;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] addr_q, wdata_q;
    logic                  last;
    dev_latency_timer #(.W(CNT_WIDTH)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ISSUE && !wr_q),
        .load_val (CNT_WIDTH'(READ_LATENCY)),
        .dec      (state == WAIT),
        .last     (last)
    );
    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    // request fields are captured only on acceptance so later input changes are ignored
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && req_valid) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    // response data: cleared for writes, sampled from the shared read bus only on the last wait cycle
    always_ff @(posedge clk or posedge rst)
        if (rst) rsp_rdata <= '0;
        else if (state == ISSUE && wr_q) rsp_rdata <= '0;
        else if (state == WAIT && last) rsp_rdata <= dev_rdata;
    // next state and outputs; every dev_* output is zero outside ISSUE to keep the OR bus clean
    always_comb begin
        state_n     = state;
        req_ready   = state == IDLE;
        rsp_valid   = state == DONE;
        dev_en      = state == ISSUE;
        dev_we      = state == ISSUE && wr_q;
        dev_address = state == ISSUE ? addr_q : '0;
        dev_wdata   = state == ISSUE && wr_q ? wdata_q : '0;
        case (state)
            IDLE:    state_n = req_valid ? ISSUE : IDLE;
            ISSUE:   state_n = wr_q ? DONE : WAIT;
            WAIT:    state_n = last ? DONE : WAIT;
            default: state_n = rsp_ready ? IDLE : DONE;
        endcase
    end
endmodule

// File: tb/tb_dev_bus_master.sv
// tb_dev_bus_master: transaction-timing model plus emulated device for latencies 1 and 3
module tb_dev_bus_master;
    localparam int DW = 16;
    localparam int L0 = 1;
    localparam int L1 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic          req_valid[2], req_write[2], rsp_ready[2];
    logic [DW-1:0] req_addr[2], req_wdata[2], dev_rdata[2];
    logic          req_ready[2], rsp_valid[2], dev_en[2], dev_we[2];
    logic [DW-1:0] rsp_rdata[2], dev_address[2], dev_wdata[2];

    always #5 clk = ~clk;

    dev_bus_master #(.DATA_WIDTH(DW), .READ_LATENCY(L0)) u0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .dev_en(dev_en[0]), .dev_we(dev_we[0]), .dev_address(dev_address[0]),
        .dev_wdata(dev_wdata[0]), .dev_rdata(dev_rdata[0])
    );
    dev_bus_master #(.DATA_WIDTH(DW), .READ_LATENCY(L1)) u1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .dev_en(dev_en[1]), .dev_we(dev_we[1]), .dev_address(dev_address[1]),
        .dev_wdata(dev_wdata[1]), .dev_rdata(dev_rdata[1])
    );

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    // transaction model: accept cycle a -> issue at a+1 -> response from a+2 (write) or a+2+L (read)
    bit            act[2];
    int            iss[2];
    bit            m_wr[2];
    logic [DW-1:0] m_addr[2], m_wd[2], m_rd[2], last_rd[2];
    logic [DW-1:0] mmem[2][256];
    // emulated device: memory behind the port, read data valid exactly L cycles after enable
    logic [DW-1:0] dmem[2][256];
    int            rd_cyc[2];
    logic [DW-1:0] rd_val[2];
    bit            prev_en[2];
    int            en_cnt[2];

    function automatic int lat(int i);
        return i == 0 ? L0 : L1;
    endfunction

    function automatic int done_of(int i);
        return iss[i] + 1 + (m_wr[i] ? 0 : lat(i));
    endfunction

    task automatic chk(string nm, int i, logic [DW-1:0] got, logic [DW-1:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s[%0d] cyc %0d: got %h want %h", nm, i, cyc, got, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // model update from sampled request/response inputs
    always @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                act[i]     <= 1'b0;
                last_rd[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!act[i] && req_valid[i]) begin
                    act[i]    <= 1'b1;
                    iss[i]    <= cyc + 1;
                    m_wr[i]   <= req_write[i];
                    m_addr[i] <= req_addr[i];
                    m_wd[i]   <= req_wdata[i];
                    m_rd[i]   <= req_write[i] ? '0 : mmem[i][req_addr[i][7:0]];
                    if (req_write[i]) mmem[i][req_addr[i][7:0]] <= req_wdata[i];
                end else if (act[i] && cyc >= done_of(i) && rsp_ready[i]) begin
                    act[i]     <= 1'b0;
                    last_rd[i] <= m_rd[i];
                end
            end
        end

    // per-cycle comparison against the model, plus device emulation
    always @(negedge clk)
        for (int i = 0; i < 2; i++) begin
            bit issue, done;
            issue = act[i] && cyc == iss[i];
            done  = act[i] && cyc >= done_of(i);
            chk("req_ready", i, req_ready[i], !act[i]);
            chk("rsp_valid", i, rsp_valid[i], done);
            chk("dev_en", i, dev_en[i], issue);
            chk("dev_we", i, dev_we[i], issue && m_wr[i]);
            chk("dev_address", i, dev_address[i], issue ? m_addr[i] : '0);
            chk("dev_wdata", i, dev_wdata[i], issue && m_wr[i] ? m_wd[i] : '0);
            chk("dev_en_adjacent", i, dev_en[i] && prev_en[i], 0);
            if (done) chk("rsp_rdata", i, rsp_rdata[i], m_rd[i]);
            else if (!act[i]) chk("rsp_rdata_held", i, rsp_rdata[i], last_rd[i]);
            prev_en[i] <= dev_en[i];
            if (dev_en[i] === 1'b1) begin
                en_cnt[i] <= en_cnt[i] + 1;
                if (dev_we[i]) dmem[i][dev_address[i][7:0]] <= dev_wdata[i];
                else begin
                    rd_cyc[i] <= cyc + lat(i);
                    rd_val[i] <= dmem[i][dev_address[i][7:0]];
                end
            end
        end

    // device read bus: valid data only in the cycle it is due, all ones otherwise
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) dev_rdata[i] = cyc == rd_cyc[i] ? rd_val[i] : 16'hFFFF;
    end

    task automatic do_req(int i, bit wr, logic [DW-1:0] a, logic [DW-1:0] d, bit keep, output int waited);
        bit ok;
        int n;
        ok = 1'b0;
        n = 0;
        req_valid[i] = 1'b1;
        req_write[i] = wr;
        req_addr[i]  = a;
        req_wdata[i] = d;
        while (!ok && n < 60) begin
            @(negedge clk);
            ok = req_ready[i];
            @(posedge clk);
            #1;
            n++;
        end
        waited = n;
        if (!ok) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout[%0d]: got no accept want accept within 60 cycles", i);
        end
        if (!keep) req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(int i);
        int n;
        n = 0;
        @(negedge clk);
        while (rsp_valid[i] !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (rsp_valid[i] !== 1'b1) begin
            compared++;
            mismatched++;
            $display("FAIL rsp_timeout[%0d]: got no rsp_valid want rsp_valid within 60 cycles", i);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200us");
        $fatal(1);
    end

    initial begin
        int w, e0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            rsp_ready[i] = 1'b1;
            dev_rdata[i] = 16'hFFFF;
            rd_cyc[i]    = -1;
            rd_val[i]    = '0;
            prev_en[i]   = 1'b0;
            en_cnt[i]    = 0;
            for (int a = 0; a < 256; a++) begin
                mmem[i][a] = 16'(a * 16'h0101) ^ 16'h5A5A;
                dmem[i][a] = mmem[i][a];
            end
            mmem[i][8] = 16'h1234;  dmem[i][8] = 16'h1234;
            mmem[i][16] = 16'hBEEF; dmem[i][16] = 16'hBEEF;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", 0, req_ready[0], 1);
        chk("reset_rsp_rdata", 1, rsp_rdata[1], 0);
        @(posedge clk);
        #1;

        // single write: exactly one enable pulse, zero response data
        e0 = en_cnt[0];
        do_req(0, 1'b1, 16'h0004, 16'h00A5, 1'b0, w);
        wait_rsp(0);
        chk("wr_rdata_lit", 0, rsp_rdata[0], 16'h0000);
        chk("wr_en_pulses_lit", 0, 16'(en_cnt[0] - e0), 1);
        @(posedge clk);
        #1;

        // read with latency 1
        do_req(0, 1'b0, 16'h0008, 16'h0000, 1'b0, w);
        wait_rsp(0);
        chk("rd_l1_lit", 0, rsp_rdata[0], 16'h1234);
        @(posedge clk);
        #1;

        // read with latency 3, bus all ones except in the third wait cycle
        do_req(1, 1'b0, 16'h0010, 16'h0000, 1'b0, w);
        wait_rsp(1);
        chk("rd_l3_lit", 1, rsp_rdata[1], 16'hBEEF);
        @(posedge clk);
        #1;

        // back-pressure: response held, competing request ignored until IDLE
        rsp_ready[1] = 1'b0;
        do_req(1, 1'b0, 16'h0008, 16'h0000, 1'b0, w);
        wait_rsp(1);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_addr[1]  = 16'h0040;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_rsp_valid_lit", 1, rsp_valid[1], 1);
            chk("bp_rsp_rdata_lit", 1, rsp_rdata[1], 16'h1234);
            chk("bp_req_ready_lit", 1, req_ready[1], 0);
            @(posedge clk);
            #1;
        end
        rsp_ready[1] = 1'b1;
        do_req(1, 1'b0, 16'h0040, 16'h0000, 1'b0, w);
        chk("bp_accept_wait_lit", 1, 16'(w), 2);
        wait_rsp(1);
        chk("bp_second_rd_lit", 1, rsp_rdata[1], 16'h1A1A);
        @(posedge clk);
        #1;

        // reset during WAIT of a latency-3 read
        do_req(1, 1'b0, 16'h0010, 16'h0000, 1'b0, w);
        @(posedge clk);
        #1;
        #1 rst = 1'b1;
        #1;
        chk("arst_req_ready_lit", 1, req_ready[1], 1);
        chk("arst_rsp_valid_lit", 1, rsp_valid[1], 0);
        chk("arst_dev_en_lit", 1, dev_en[1], 0);
        chk("arst_rsp_rdata_lit", 1, rsp_rdata[1], 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("post_rst_no_rsp_lit", 1, rsp_valid[1], 0);
        end
        @(posedge clk);
        #1;

        // back-to-back alternating writes and reads on both latencies
        for (int i = 0; i < 2; i++) begin
            do_req(i, 1'b1, 16'h0020, 16'h1111, 1'b1, w);
            do_req(i, 1'b0, 16'h0020, 16'h0000, 1'b1, w);
            do_req(i, 1'b1, 16'h0021, 16'h2222, 1'b1, w);
            do_req(i, 1'b0, 16'h0021, 16'h0000, 1'b0, w);
            wait_rsp(i);
            chk("b2b_last_rd_lit", i, rsp_rdata[i], 16'h2222);
            repeat (3) @(posedge clk);
            #1;
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/dev_bus_master.md
Name: dev_bus_master

Overview:
- Initiator side of the memory-mapped device port used by the computing device and its adder/compare units (device_en / address / i_data in, o_data out).
- Accepts single-beat read or write requests from the core and drives the device port with correctly timed enable, address and write data.
- For reads, waits a fixed device latency and captures the OR-combined device read bus.
- Returns one response per request through a valid/ready handshake. One transaction is outstanding at a time.

Parameters:
- DATA_WIDTH, 16, width of address, write data and read data; equals the shared DATA_WIDTH constant.
- READ_LATENCY, 1, clock edges from the device-enable cycle to valid device read data; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  master can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  DATA_WIDTH  device port address.
- req_wdata  in  DATA_WIDTH  write operand.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  DATA_WIDTH  read result; 0 for writes.
- dev_en  out  1  device enable; connects to device_en.
- dev_we  out  1  write strobe qualifying dev_en.
- dev_address  out  DATA_WIDTH  connects to address.
- dev_wdata  out  DATA_WIDTH  connects to i_data.
- dev_rdata  in  DATA_WIDTH  connects to o_data, the OR of all device outputs.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE.
  - req_ready=1. rsp_valid=0. rsp_rdata=0.
  - dev_en=0, dev_we=0, dev_address=0, dev_wdata=0.
  - Latency counter = 0.
  - Any in-flight transaction is discarded with no response.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_write, req_addr and req_wdata, then go to ISSUE.
  - Request inputs are ignored in every other state.
- ISSUE (exactly 1 cycle):
  - dev_en=1, dev_address=latched address.
  - dev_we=latched write bit.
  - dev_wdata=latched wdata for writes, 0 for reads.
  - Write: go to DONE with rsp_rdata=0.
  - Read: load counter with READ_LATENCY, go to WAIT.
- WAIT:
  - All dev_* outputs are 0.
  - Counter decrements each cycle.
  - On the edge where counter==1, register dev_rdata into rsp_rdata and go to DONE.
  - WAIT therefore lasts exactly READ_LATENCY cycles.
- DONE:
  - rsp_valid=1; rsp_rdata is held stable.
  - On rsp_ready, go to IDLE; rsp_valid drops next cycle.
  - rsp_rdata keeps its value until the next capture.
- req_ready=0 in ISSUE, WAIT and DONE. There is no request/response overlap and no bypass.
- Minimum transaction length:
  - Write: 3 cycles (IDLE accept, ISSUE, DONE with rsp_ready=1).
  - Read: 3 + READ_LATENCY cycles.
- All dev_* outputs are 0 outside ISSUE. This is required because the device read bus is an OR of all units, so stray drive corrupts other transactions.
- dev_rdata is sampled only on the capture edge; its value on other cycles is ignored.
- rsp_ready held high in DONE: IDLE follows, and a new request may be accepted in that IDLE cycle.
- Reset asserted in any state forces the reset values immediately. After release, first acceptance happens on the first rising edge with req_valid=1.

Decomposition:
- Shared package/define file holds DATA_WIDTH and the state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3), reusable by other initiators.
- The latency counter is a natural sub-module, dev_latency_timer: load value, decrement, and a "last" flag.
- The rest is a single FSM plus capture registers.

Test Plan:
- Write: req_write=1, addr=0x0004, wdata=0x00A5 → exactly one cycle with dev_en=1, dev_we=1, dev_address=0x0004, dev_wdata=0x00A5; then rsp_valid=1, rsp_rdata=0x0000.
- Read, READ_LATENCY=1: addr=0x0008, dev_rdata=0x1234 driven on the cycle after ISSUE → rsp_valid 2 cycles after ISSUE with rsp_rdata=0x1234; dev_wdata=0 during ISSUE.
- Read, READ_LATENCY=3: dev_rdata=0xBEEF only in the 3rd WAIT cycle, 0xFFFF in the other cycles → rsp_rdata=0xBEEF.
- Back-pressure: rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stable, req_ready=0, and a second req_valid is not accepted. After rsp_ready=1, the next request is accepted in the IDLE cycle.
- Reset in WAIT: assert rst mid-read → all outputs return to reset values asynchronously, and no rsp_valid appears after release.
- Back-to-back: 4 alternating writes and reads with req_valid and rsp_ready held high → dev_en pulses are single-cycle, never adjacent, and responses arrive in request order with correct data.
